comb_job_scheduler: RTL and testbench
=====================================

COMB_JOB_SCHEDULER -- requirements
Module: comb_job_scheduler

Interface
REQ-001 Parameter W_NM, default 4: bit width of the n and m operands.
REQ-002 Parameter W_RES, default 16: bit width of the combination result C(n,m).
REQ-003 Parameter DEPTH, default 4, power of 2, minimum 2: request queue entries.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only with COMB_TIMEOUT_EN.
REQ-005 clk input 1: rising-edge clock.
REQ-006 rst input 1: reset, asynchronous, active-high.
REQ-007 req_valid input 1, req_ready output 1, req_n input W_NM, req_m input W_NM: request handshake and operands.
REQ-008 res_valid output 1, res_ready input 1, res_data output W_RES, res_err output 1: result handshake.
REQ-009 eng_start output 1, eng_n output W_NM, eng_m output W_NM: launch interface to the combination engine.
REQ-010 eng_done input 1, eng_result input W_RES: engine completion pulse and value.
REQ-011 eng_abort output 1: engine abort pulse.
REQ-012 jobs_done output 8: completed-job counter.

Function
REQ-013 Transfers: a request is accepted when req_valid=1 and req_ready=1; a result is consumed when res_valid=1 and res_ready=1.
REQ-014 Queue: accepted requests are queued in FIFO order; req_ready=1 exactly when the queue is not full, independent of req_valid and of the FSM.
REQ-015 Queue full: no write occurs, including in a cycle that also pops; a push and a pop in the same non-full cycle both take effect.
REQ-016 FSM states: IDLE, LAUNCH, WAIT, OUT; reset state is IDLE.
REQ-017 IDLE, queue not empty: pop the head into n_q/m_q; if m>n, set res_q=0, err_q=0 and go to OUT (bypass, no eng_start); otherwise go to LAUNCH.
REQ-018 IDLE, queue empty: remain in IDLE.
REQ-019 LAUNCH: eng_start=1 for exactly one cycle, then go to WAIT.
REQ-020 eng_n/eng_m: driven from n_q/m_q and held stable from LAUNCH through the end of WAIT.
REQ-021 WAIT: on eng_done=1, capture eng_result into res_q, clear err_q and go to OUT; eng_done in any other state is ignored.
REQ-022 OUT: res_valid=1, res_data=res_q and res_err=err_q, all held stable until the transfer; on transfer, increment jobs_done (mod 256) and go to IDLE.
REQ-023 Latency, empty queue and IDLE: request accepted at edge t, pop at t+1, eng_start high in cycle t+2; bypass has res_valid high in cycle t+2.
REQ-024 Result ordering: results are emitted strictly in request order, with only one job in flight.

Reset
REQ-025 On rst: queue emptied, state IDLE, req_ready=1, res_valid=0, res_data=0, res_err=0, eng_start=0, eng_abort=0, eng_n=0, eng_m=0, jobs_done=0, watchdog counter=0.
REQ-026 rst asserted mid-operation (any state) discards the in-flight job and all queued jobs, with no result emitted.

Configuration
REQ-027 Macro COMB_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle without eng_done.
REQ-028 With COMB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1 without eng_done: eng_abort=1 for one cycle, res_q = all ones, err_q=1, go to OUT.
REQ-029 With COMB_TIMEOUT_EN, eng_done in the same cycle as the timeout wins: normal capture, no abort.
REQ-030 Macro COMB_TIMEOUT_EN undefined: no counter, eng_abort tied 0, res_err tied 0, WAIT lasts until eng_done.

Structure
REQ-031 Package comb_pkg holds the FSM state enum, the W_NM/W_RES defaults and the RES_ERR_VALUE (all-ones) constant.
REQ-032 The queue is a sub-module comb_req_fifo (DEPTH x 2*W_NM, full/empty flags, wrap-around pointers); the FSM, watchdog and counter live in the top module.

Verification
REQ-033 Enqueue n=5,m=2 with an engine model answering 10 after 20 cycles: one eng_start pulse with eng_n=5, eng_m=2; then res_data=10, res_err=0, jobs_done=1.
REQ-034 Enqueue n=3,m=5: no eng_start; res_data=0, res_valid in the second cycle after acceptance.
REQ-035 Hold res_ready=0 and push 6 requests back-to-back: req_ready drops after the 4th accept (DEPTH=4) plus the in-flight pop, then rises on the first result consumed; all results are in order.
REQ-036 Push while full, and push and pop in the same cycle, at the wrap boundary: no loss and no duplication of the 8 jobs.
REQ-037 COMB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine never signals done: eng_abort pulses after 16 WAIT cycles; res_data=16'hFFFF, res_err=1.
REQ-038 Assert rst during WAIT with 2 jobs queued: all outputs return to reset values, no result is emitted, and a following job runs normally.

Source files
------------

// File: rtl/comb_pkg.sv
// Shared types and constants for the combination job scheduler.
// Optional watchdog is enabled by defining COMB_TIMEOUT_EN.
package comb_pkg;

    localparam int W_NM_DEF  = 4;
    localparam int W_RES_DEF = 16;

    // Result reported on a watchdog abort; sliced to the result width by users.
    localparam logic [63:0] RES_ERR_VALUE = '1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/comb_req_fifo.sv
// Request queue: DEPTH entries, wrap-around pointers with an extra lap bit
// so full and empty are distinguishable. Head word is visible combinationally.
module comb_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_write;
    logic             do_read;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // A full queue refuses the write even when the same cycle pops.
    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/comb_job_scheduler.sv
// Queues C(n,m) requests and runs them one at a time on an external engine.
// Define COMB_TIMEOUT_EN to enable the WAIT-state watchdog and abort path.
module comb_job_scheduler
    import comb_pkg::*;
#(
    parameter int W_NM           = W_NM_DEF,
    parameter int W_RES          = W_RES_DEF,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W_NM-1:0]  req_n,
    input  logic [W_NM-1:0]  req_m,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_RES-1:0] res_data,
    output logic             res_err,
    output logic             eng_start,
    output logic [W_NM-1:0]  eng_n,
    output logic [W_NM-1:0]  eng_m,
    input  logic             eng_done,
    input  logic [W_RES-1:0] eng_result,
    output logic             eng_abort,
    output logic [7:0]       jobs_done
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("comb_job_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    state_t            state_reg;
    logic [W_NM-1:0]   n_q;
    logic [W_NM-1:0]   m_q;
    logic [W_RES-1:0]  res_q;
    logic              res_valid_reg;
    logic              eng_start_reg;
    logic [7:0]        jobs_done_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [2*W_NM-1:0] fifo_head;
    logic [W_NM-1:0]   head_n;
    logic [W_NM-1:0]   head_m;

    assign fifo_pop = (state_reg == IDLE) && !fifo_empty;
    assign head_n   = fifo_head[2*W_NM-1:W_NM];
    assign head_m   = fifo_head[W_NM-1:0];

    comb_req_fifo #(
        .WIDTH (2 * W_NM),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req_valid),
        .wr_data ({req_n, req_m}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign res_valid = res_valid_reg;
    assign res_data  = res_q;
    assign eng_start = eng_start_reg;
    assign eng_n     = n_q;
    assign eng_m     = m_q;
    assign jobs_done = jobs_done_reg;

`ifdef COMB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_q;
    logic            eng_abort_reg;

    assign res_err   = err_q;
    assign eng_abort = eng_abort_reg;
`else
    assign res_err   = 1'b0;
    assign eng_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            n_q           <= '0;
            m_q           <= '0;
            res_q         <= '0;
            res_valid_reg <= 1'b0;
            eng_start_reg <= 1'b0;
            jobs_done_reg <= '0;
`ifdef COMB_TIMEOUT_EN
            wd_cnt_reg    <= '0;
            err_q         <= 1'b0;
            eng_abort_reg <= 1'b0;
`endif
        end else begin
            eng_start_reg <= 1'b0;
`ifdef COMB_TIMEOUT_EN
            eng_abort_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        n_q <= head_n;
                        m_q <= head_m;
                        // m > n has C(n,m) = 0, so skip the engine entirely.
                        if (head_m > head_n) begin
                            res_q         <= '0;
                            res_valid_reg <= 1'b1;
`ifdef COMB_TIMEOUT_EN
                            err_q         <= 1'b0;
`endif
                            state_reg     <= OUT;
                        end else begin
                            eng_start_reg <= 1'b1;
                            state_reg     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
`ifdef COMB_TIMEOUT_EN
                    wd_cnt_reg <= '0;
`endif
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        res_q         <= eng_result;
                        res_valid_reg <= 1'b1;
`ifdef COMB_TIMEOUT_EN
                        err_q         <= 1'b0;
`endif
                        state_reg     <= OUT;
                    end
`ifdef COMB_TIMEOUT_EN
                    else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        res_q         <= RES_ERR_VALUE[W_RES-1:0];
                        err_q         <= 1'b1;
                        eng_abort_reg <= 1'b1;
                        res_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        jobs_done_reg <= jobs_done_reg + 8'd1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_job_scheduler.sv
// Scoreboard bench for comb_job_scheduler with a behavioural engine model.
// Define COMB_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_comb_job_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_n;
    logic [3:0]  req_m;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;
    logic        eng_start;
    logic [3:0]  eng_n;
    logic [3:0]  eng_m;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        eng_abort;
    logic [7:0]  jobs_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] exp_res_q[$];     // {err, data}
    logic [7:0]  exp_launch_q[$];  // {n, m}
    logic [7:0]  exp_jobs = 8'd0;
    int          cyc = 0;
    int          abort_cnt = 0;

    int  eng_delay = 20;
    bit  eng_hang = 1'b0;
    bit  eng_busy = 1'b0;
    int  eng_cnt = 0;
    bit  exp_timeout = 1'b0;
    bit  rnd_ready = 1'b0;

    comb_job_scheduler #(
        .W_NM           (4),
        .W_RES          (16),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n      (req_n),
        .req_m      (req_m),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .eng_start  (eng_start),
        .eng_n      (eng_n),
        .eng_m      (eng_m),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .eng_abort  (eng_abort),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] binom(input int n, input int m);
        longint r = 1;
        if (m > n) return 16'd0;
        for (int i = 1; i <= m; i++) r = r * (n - m + i) / i;
        return r[15:0];
    endfunction

    // Engine model: answers C(n,m) eng_delay cycles after eng_start.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (rst || eng_abort) begin
            eng_busy = 1'b0;
        end else if (eng_start) begin
            eng_busy   = 1'b1;
            eng_cnt    = eng_delay;
            eng_result = binom(int'(eng_n), int'(eng_m));
        end else if (eng_busy && !eng_hang) begin
            if (eng_cnt <= 1) begin
                eng_done = 1'b1;
                eng_busy = 1'b0;
            end else begin
                eng_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
    end

    // Monitor runs just after the negedge so all bench drives have settled.
    bit          stall_q = 1'b0;
    logic [15:0] held_data;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("res_hold_valid", 32'(res_valid), 32'd1);
                check("res_hold_data", 32'(res_data), 32'(held_data));
            end
            if (eng_abort) abort_cnt++;
            if (eng_start) begin
                if (exp_launch_q.size() == 0) begin
                    check("unexpected_start", 32'(eng_start), 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_launch_q.pop_front();
                    check("eng_n", 32'(eng_n), 32'(e[7:4]));
                    check("eng_m", 32'(eng_m), 32'(e[3:0]));
                end
            end
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_res", 32'(res_valid), 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_res_q.pop_front();
                    $display("[TB] result data=%0h err=%0b jobs_done=%0d", res_data, res_err, jobs_done);
                    check("res_data", 32'(res_data), 32'(e[15:0]));
                    check("res_err", 32'(res_err), 32'(e[16]));
                    check("jobs_done", 32'(jobs_done), 32'(exp_jobs));
                    exp_jobs = exp_jobs + 8'd1;
                end
            end
            stall_q   = res_valid && !res_ready;
            held_data = res_data;
        end
    end

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic send(input logic [3:0] n, input logic [3:0] m);
        int waited = 0;
        req_n     = n;
        req_m     = m;
        req_valid = 1'b1;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        $display("[TB] request n=%0d m=%0d accepted", n, m);
        if (m > n) begin
            exp_res_q.push_back({1'b0, 16'd0});
        end else begin
            exp_launch_q.push_back({n, m});
            if (exp_timeout) exp_res_q.push_back({1'b1, 16'hFFFF});
            else             exp_res_q.push_back({1'b0, binom(int'(n), int'(m))});
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_res_q.size() != 0 || exp_launch_q.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", 32'(exp_res_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        check({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        check({pfx, "_res_data"},  32'(res_data),  32'd0);
        check({pfx, "_res_err"},   32'(res_err),   32'd0);
        check({pfx, "_eng_start"}, 32'(eng_start), 32'd0);
        check({pfx, "_eng_abort"}, 32'(eng_abort), 32'd0);
        check({pfx, "_eng_n"},     32'(eng_n),     32'd0);
        check({pfx, "_eng_m"},     32'(eng_m),     32'd0);
        check({pfx, "_jobs_done"}, 32'(jobs_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int n_tab [8] = '{2, 9, 1, 7, 3, 12, 0, 15};
        int m_tab [8] = '{5, 4, 3, 0, 6, 12, 1, 8};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = '0;
        req_m     = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Engine job with latency check on eng_start.
        eng_delay = 20;
        res_ready = 1'b1;
        send(4'd5, 4'd2);
        check("t1_start_early", 32'(eng_start), 32'd0);
        @(negedge clk);
        check("t1_start", 32'(eng_start), 32'd1);
        check("t1_eng_n", 32'(eng_n), 32'd5);
        check("t1_eng_m", 32'(eng_m), 32'd2);
        drain();
        check("t1_jobs", 32'(jobs_done), 32'd1);

        // Bypass job: result in the second cycle after acceptance, no launch.
        res_ready = 1'b0;
        send(4'd3, 4'd5);
        check("t2_valid_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("t2_valid", 32'(res_valid), 32'd1);
        check("t2_data", 32'(res_data), 32'd0);
        check("t2_no_start", 32'(eng_start), 32'd0);
        res_ready = 1'b1;
        drain();

        // Back-pressure: one in flight plus four queued fills the queue.
        eng_delay = 3;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'(8 + i), 4'(i + 1));
        check("t3_full", 32'(req_ready), 32'd0);
        fork
            send(4'd13, 4'd6);
            begin
                int k = 0;
                repeat (20) @(negedge clk);
                check("t3_full_hold", 32'(req_ready), 32'd0);
                res_ready = 1'b1;
                while (!req_ready && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                check("t3_ready_rise", 32'(req_ready), 32'd1);
            end
        join
        drain();

        // Mixed jobs across the pointer wrap with random result back-pressure.
        eng_delay = 2;
        rnd_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(4'(n_tab[i]), 4'(m_tab[i]));
        drain();
        rnd_ready = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_jobs_total", 32'(jobs_done), 32'(exp_jobs));

        // Reset while waiting on the engine with two jobs queued.
        eng_hang = 1'b1;
        send(4'd7, 4'd3);
        send(4'd4, 4'd1);
        send(4'd6, 4'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_res_q.delete();
        exp_launch_q.delete();
        exp_jobs = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst      = 1'b0;
        eng_hang = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_result", 32'(res_valid), 32'd0);
        check("midrst_no_start", 32'(eng_start), 32'd0);
        send(4'd6, 4'd3);
        drain();
        check("midrst_jobs", 32'(jobs_done), 32'd1);

`ifdef COMB_TIMEOUT_EN
        begin
            int k = 0;
            int t_launch;
            eng_hang    = 1'b1;
            exp_timeout = 1'b1;
            abort_cnt   = 0;
            send(4'd5, 4'd2);
            while (!eng_start && k < 10) begin
                @(negedge clk);
                k++;
            end
            t_launch = cyc;
            k = 0;
            while (!eng_abort && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("to_abort_seen", 32'(eng_abort), 32'd1);
            check("to_abort_time", 32'(cyc - t_launch), 32'd17);
            drain();
            check("to_abort_count", 32'(abort_cnt), 32'd1);
            exp_timeout = 1'b0;
            eng_hang    = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
